// File: rtl/nibbler_pkg.sv
// nibbler_pkg: shared widths, starvation default and arbiter state encoding.
package nibbler_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 4;
    localparam int CNT_W = 3;
    localparam int STARVE_LIMIT_DEF = 8;
    typedef enum logic [1:0] {IDLE, D_SETUP, D_STROBE, D_ACK} arb_state_e;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: CPU, debug and RAM-side signals of the RAM arbiter.
interface ram_arbiter_if;
    import nibbler_pkg::*;
    logic cpuReq, cpuWe, cpuWait, dbgReq, dbgWe, dbgAck, holdCpu, notCsRam, notWeRam;
    logic [ADDR_W-1:0] cpuAddr, dbgAddr, ramAddr;
    logic [DATA_W-1:0] cpuWData, cpuRData, dbgWData, dbgRData, ramWData, ramRData;
    modport slave (
        input  cpuReq, cpuWe, cpuAddr, cpuWData, dbgReq, dbgWe, dbgAddr, dbgWData, ramRData,
        output cpuRData, cpuWait, dbgAck, dbgRData, holdCpu, notCsRam, notWeRam, ramAddr, ramWData
    );
    modport master (
        output cpuReq, cpuWe, cpuAddr, cpuWData, dbgReq, dbgWe, dbgAddr, dbgWData, ramRData,
        input  cpuRData, cpuWait, dbgAck, dbgRData, holdCpu, notCsRam, notWeRam, ramAddr, ramWData
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between the CPU (priority, pass-through)
// and a debug/loader port that forces a hold after STARVE_LIMIT lost cycles.
module ram_arbiter
    import nibbler_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic clk,
    input logic notReset,
    ram_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STARVE_LIMIT - 1);
    arb_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic hold_q, hold_d, we_q, we_d, pass;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;

    assign pass = (state_q == IDLE) && !hold_q;

    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            hold_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            hold_q <= hold_d;
            we_q <= we_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        hold_d = hold_q;
        we_d = we_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                // a hold with no request left behind simply releases the CPU
                if (!bus.dbgReq) begin
                    cnt_d = '0;
                    hold_d = 1'b0;
                end else if (bus.cpuReq && !hold_q) begin
                    if (cnt_q == CNT_TOP) hold_d = 1'b1;
                    else cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = D_SETUP;
                    cnt_d = '0;
                    we_d = bus.dbgWe;
                    addr_d = bus.dbgAddr;
                    wdata_d = bus.dbgWData;
                end
            end
            D_SETUP: state_d = D_STROBE;
            D_STROBE: begin
                state_d = D_ACK;
                rdata_d = we_q ? rdata_q : bus.ramRData;
            end
            default: begin
                state_d = IDLE;
                hold_d = 1'b0;
            end
        endcase
    end

    assign bus.ramAddr = pass ? bus.cpuAddr : addr_q;
    assign bus.ramWData = pass ? bus.cpuWData : wdata_q;
    assign bus.notCsRam = pass ? !bus.cpuReq : (state_q != D_STROBE);
    assign bus.notWeRam = pass ? !(bus.cpuReq && bus.cpuWe) : !((state_q == D_STROBE) && we_q);
    assign bus.cpuRData = bus.ramRData;
    assign bus.cpuWait = bus.cpuReq && !pass;
    assign bus.dbgAck = state_q == D_ACK;
    assign bus.dbgRData = rdata_q;
    assign bus.holdCpu = hold_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: random and directed checks of ram_arbiter against an
// abstract memory/transaction model held in the bench.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic notReset;
    int total = 0;
    int bad = 0;
    logic [3:0] mem [4096] = '{default: 4'h0};
    logic [3:0] ref_mem [4096] = '{default: 4'h0};
    logic [3:0] last_rd = 4'h0;
    logic [11:0] pool [8];
    int n;

    ram_arbiter_if bus ();
    ram_arbiter #(.STARVE_LIMIT(8)) dut (.clk(clk), .notReset(notReset), .bus(bus));

    always #5 clk = ~clk;

    assign bus.ramRData = mem[bus.ramAddr];
    always @(posedge clk)
        if (!bus.notCsRam && !bus.notWeRam) mem[bus.ramAddr] <= bus.ramWData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [3:0] d);
        @(negedge clk);
        bus.cpuReq = 1'b1; bus.cpuWe = 1'b1; bus.cpuAddr = a; bus.cpuWData = d;
        #1;
        chk("cpu_wr_cs", bus.notCsRam, 0);
        chk("cpu_wr_we", bus.notWeRam, 0);
        chk("cpu_wr_addr", bus.ramAddr, a);
        chk("cpu_wr_data", bus.ramWData, d);
        chk("cpu_wr_wait", bus.cpuWait, 0);
        ref_mem[a] = d;
    endtask

    task automatic cpu_read(input logic [11:0] a);
        @(negedge clk);
        bus.cpuReq = 1'b1; bus.cpuWe = 1'b0; bus.cpuAddr = a; bus.dbgReq = 1'b0;
        #1;
        chk("cpu_rd_we", bus.notWeRam, 1);
        chk("cpu_rd_data", bus.cpuRData, ref_mem[a]);
    endtask

    task automatic dbg_op(input logic we, input logic [11:0] a, input logic [3:0] d,
                          input bit drop, input bit cpu_mid, input logic [11:0] ca, input logic [3:0] cd);
        @(negedge clk);
        bus.cpuReq = 1'b0; bus.dbgReq = 1'b1; bus.dbgWe = we; bus.dbgAddr = a; bus.dbgWData = d;
        #1;
        chk("grant_ack", bus.dbgAck, 0);
        chk("grant_cs", bus.notCsRam, 1);
        @(negedge clk);
        if (drop) bus.dbgReq = 1'b0;
        bus.dbgAddr = ~a; bus.dbgWData = ~d; bus.dbgWe = ~we;
        #1;
        chk("setup_cs", bus.notCsRam, 1);
        chk("setup_we", bus.notWeRam, 1);
        chk("setup_addr", bus.ramAddr, a);
        chk("setup_ack", bus.dbgAck, 0);
        @(negedge clk);
        if (cpu_mid) begin
            bus.cpuReq = 1'b1; bus.cpuWe = 1'b1; bus.cpuAddr = ca; bus.cpuWData = cd;
        end
        #1;
        chk("strobe_cs", bus.notCsRam, 0);
        chk("strobe_we", bus.notWeRam, !we);
        chk("strobe_addr", bus.ramAddr, a);
        chk("strobe_wait", bus.cpuWait, cpu_mid);
        if (we) chk("strobe_data", bus.ramWData, d);
        @(negedge clk);
        bus.dbgReq = 1'b0;
        #1;
        if (we) ref_mem[a] = d;
        else last_rd = ref_mem[a];
        chk("ack", bus.dbgAck, 1);
        chk("ack_rdata", bus.dbgRData, last_rd);
        chk("ack_cs", bus.notCsRam, 1);
        chk("ack_wait", bus.cpuWait, cpu_mid);
        @(negedge clk);
        #1;
        chk("ack_pulse", bus.dbgAck, 0);
        if (cpu_mid) begin
            chk("cpu_back_wait", bus.cpuWait, 0);
            chk("cpu_back_addr", bus.ramAddr, ca);
            chk("cpu_back_cs", bus.notCsRam, 0);
            chk("cpu_back_we", bus.notWeRam, 0);
            ref_mem[ca] = cd;
        end else chk("idle_cs", bus.notCsRam, 1);
    endtask

    initial begin
        notReset = 1'b0;
        bus.cpuReq = 1'b0; bus.cpuWe = 1'b0; bus.cpuAddr = '0; bus.cpuWData = '0;
        bus.dbgReq = 1'b0; bus.dbgWe = 1'b0; bus.dbgAddr = '0; bus.dbgWData = '0;
        foreach (pool[i]) pool[i] = 12'($urandom_range(4095));
        pool[0] = 12'h7FF;
        pool[1] = 12'h010;
        @(negedge clk);
        #1;
        chk("rst_hold", bus.holdCpu, 0);
        chk("rst_ack", bus.dbgAck, 0);
        chk("rst_rdata", bus.dbgRData, 0);
        chk("rst_cs", bus.notCsRam, 1);
        chk("rst_wait", bus.cpuWait, 0);
        @(negedge clk);
        notReset = 1'b1;

        cpu_write(12'h123, 4'hA);
        cpu_write(12'h7FF, 4'h5);
        for (int i = 2; i < 8; i++) cpu_write(pool[i], 4'($urandom));
        for (int i = 0; i < 8; i++) cpu_read(pool[i]);

        dbg_op(1'b0, 12'h7FF, 4'h0, 1'b0, 1'b0, 12'h0, 4'h0);
        chk("dbg_rd_7ff", bus.dbgRData, 4'h5);
        dbg_op(1'b1, 12'h010, 4'h3, 1'b1, 1'b0, 12'h0, 4'h0);
        chk("wr_keeps_rdata", bus.dbgRData, 4'h5);
        dbg_op(1'b0, 12'h010, 4'h0, 1'b0, 1'b0, 12'h0, 4'h0);
        chk("dbg_rd_010", bus.dbgRData, 4'h3);
        for (int i = 0; i < 12; i++)
            dbg_op(1'($urandom_range(1)), pool[$urandom_range(7)], 4'($urandom), 1'($urandom_range(1)),
                   (i % 4) == 3, pool[$urandom_range(7)], 4'($urandom));
        for (int i = 0; i < 8; i++) cpu_read(pool[i]);

        @(negedge clk);
        bus.cpuReq = 1'b1; bus.cpuWe = 1'b0; bus.cpuAddr = pool[2];
        bus.dbgReq = 1'b1; bus.dbgWe = 1'b0; bus.dbgAddr = pool[3];
        n = 0;
        #1;
        while (!bus.holdCpu && n < 20) begin
            chk("starve_wait", bus.cpuWait, 0);
            chk("starve_addr", bus.ramAddr, pool[2]);
            n++;
            @(negedge clk);
            #1;
        end
        chk("starve_len", n, 8);
        chk("hold_wait", bus.cpuWait, 1);
        chk("hold_cs", bus.notCsRam, 1);
        @(negedge clk);
        #1;
        chk("hold_setup_addr", bus.ramAddr, pool[3]);
        @(negedge clk);
        #1;
        chk("hold_strobe_cs", bus.notCsRam, 0);
        @(negedge clk);
        bus.dbgReq = 1'b0;
        #1;
        last_rd = ref_mem[pool[3]];
        chk("hold_ack", bus.dbgAck, 1);
        chk("hold_ack_rdata", bus.dbgRData, last_rd);
        chk("hold_ack_wait", bus.cpuWait, 1);
        @(negedge clk);
        #1;
        chk("hold_release", bus.holdCpu, 0);
        chk("hold_cpu_wait", bus.cpuWait, 0);
        chk("hold_cpu_addr", bus.ramAddr, pool[2]);
        chk("hold_cpu_data", bus.cpuRData, ref_mem[pool[2]]);

        @(negedge clk);
        bus.cpuReq = 1'b0; bus.dbgReq = 1'b1; bus.dbgWe = 1'b1;
        bus.dbgAddr = pool[4]; bus.dbgWData = ~ref_mem[pool[4]];
        @(negedge clk);
        bus.dbgReq = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_strobe", bus.notCsRam, 0);
        #1;
        notReset = 1'b0;
        #1;
        last_rd = 4'h0;
        chk("abort_cs", bus.notCsRam, 1);
        chk("abort_ack", bus.dbgAck, 0);
        chk("abort_hold", bus.holdCpu, 0);
        chk("abort_rdata", bus.dbgRData, 0);
        @(negedge clk);
        notReset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("abort_no_ack", bus.dbgAck, 0);
        end
        cpu_read(pool[4]);
        @(negedge clk);
        bus.cpuReq = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
